// File: rtl/layer_sequencer.sv
// Fixed-order stage scheduler for one CNN inference pass: launches each datapath
// stage, grants it the shared feature-map BRAM, and watchdogs it while it runs.
module layer_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 13,
    parameter int NUM_STAGES     = 3,
    parameter int TIMEOUT_CYCLES = 65536,
    localparam int SW            = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [SW-1:0]                    cur_stage,
    output logic [NUM_STAGES-1:0]            stage_start,
    input  logic [NUM_STAGES-1:0]            stage_done,
    input  logic [NUM_STAGES*ADDR_WIDTH-1:0] st_r_addr,
    input  logic [NUM_STAGES-1:0]            st_r_en,
    output logic [DATA_WIDTH-1:0]            st_r_q,
    input  logic [NUM_STAGES*ADDR_WIDTH-1:0] st_w_addr,
    input  logic [NUM_STAGES-1:0]            st_w_en,
    input  logic [NUM_STAGES-1:0]            st_w_we,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0] st_w_d,
    output logic [ADDR_WIDTH-1:0]            bram_r_addr,
    output logic                             bram_r_en,
    output logic [ADDR_WIDTH-1:0]            bram_w_addr,
    output logic                             bram_w_en,
    output logic                             bram_w_we,
    output logic [DATA_WIDTH-1:0]            bram_w_d,
    input  logic [DATA_WIDTH-1:0]            bram_r_q
);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam logic [SW-1:0] LAST_IDX = SW'(NUM_STAGES - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [SW-1:0] idx;
    logic [WW-1:0] wdog;
    logic          grant;

    logic [NUM_STAGES-1:0][ADDR_WIDTH-1:0] r_addr_v, w_addr_v;
    logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] w_d_v;

    assign r_addr_v = st_r_addr;
    assign w_addr_v = st_w_addr;
    assign w_d_v    = st_w_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            wdog  <= '0;
            error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LAUNCH;
                        idx   <= '0;
                    end
                end
                S_LAUNCH: begin
                    wdog  <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    wdog <= wdog + WW'(1);
                    // A done pulse on the limit cycle still counts as completion.
                    if (stage_done[idx]) begin
                        if (idx == LAST_IDX) begin
                            state <= S_FINISH;
                        end else begin
                            idx   <= idx + SW'(1);
                            state <= S_LAUNCH;
                        end
                    end else if (wdog == WD_MAX) begin
                        state <= S_FAULT;
                        error <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    idx   <= '0;
                end
                S_FAULT: begin
                    if (start) begin
                        error <= 1'b0;
                        idx   <= '0;
                        state <= S_LAUNCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign grant       = (state == S_LAUNCH) || (state == S_RUN);
    assign busy        = grant || (state == S_FINISH);
    assign done        = (state == S_FINISH);
    assign cur_stage   = idx;
    assign stage_start = (state == S_LAUNCH) ? (NUM_STAGES'(1) << idx) : '0;
    assign st_r_q      = bram_r_q;

    // Only the granted stage reaches the BRAM; everything else is forced to zero.
    always_comb begin
        bram_r_addr = '0;
        bram_r_en   = 1'b0;
        bram_w_addr = '0;
        bram_w_en   = 1'b0;
        bram_w_we   = 1'b0;
        bram_w_d    = '0;
        if (grant) begin
            bram_r_addr = r_addr_v[idx];
            bram_r_en   = st_r_en[idx];
            bram_w_addr = w_addr_v[idx];
            bram_w_en   = st_w_en[idx];
            bram_w_we   = st_w_we[idx];
            bram_w_d    = w_d_v[idx];
        end
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: one long-timeout instance for pass timing
// and BRAM grant, one 16-cycle-timeout instance for watchdog behaviour.
module tb_layer_sequencer;
    localparam int DW = 16;
    localparam int AW = 13;
    localparam int NS = 3;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset, start;
    logic [NS-1:0]    stage_done, st_r_en, st_w_en, st_w_we;
    logic [NS*AW-1:0] st_r_addr, st_w_addr;
    logic [NS*DW-1:0] st_w_d;
    logic [DW-1:0]    bram_r_q;

    logic busy, done, error, bram_r_en, bram_w_en, bram_w_we;
    logic [SW-1:0] cur_stage;
    logic [NS-1:0] stage_start;
    logic [DW-1:0] st_r_q, bram_w_d;
    logic [AW-1:0] bram_r_addr, bram_w_addr;

    logic busy_w, done_w, error_w, bram_r_en_w, bram_w_en_w, bram_w_we_w;
    logic [SW-1:0] cur_stage_w;
    logic [NS-1:0] stage_start_w;
    logic [DW-1:0] st_r_q_w, bram_w_d_w;
    logic [AW-1:0] bram_r_addr_w, bram_w_addr_w;

    typedef struct packed {
        logic [AW-1:0] ra;
        logic          re;
        logic [AW-1:0] wa;
        logic          we_n;
        logic          wwe;
        logic [DW-1:0] wd;
    } bram_t;

    int    vectors = 0;
    int    miscompares = 0;
    int    dly[NS];
    int    cnt[NS];
    int    exp_stage[$];
    int    exp_evt[$];
    bram_t exp_bram[$];

    layer_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_STAGES(NS), .TIMEOUT_CYCLES(65536)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .cur_stage(cur_stage), .stage_start(stage_start), .stage_done(stage_done),
        .st_r_addr(st_r_addr), .st_r_en(st_r_en), .st_r_q(st_r_q),
        .st_w_addr(st_w_addr), .st_w_en(st_w_en), .st_w_we(st_w_we), .st_w_d(st_w_d),
        .bram_r_addr(bram_r_addr), .bram_r_en(bram_r_en), .bram_w_addr(bram_w_addr),
        .bram_w_en(bram_w_en), .bram_w_we(bram_w_we), .bram_w_d(bram_w_d), .bram_r_q(bram_r_q));

    layer_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_STAGES(NS), .TIMEOUT_CYCLES(16)) dut_w (
        .clk(clk), .reset(reset), .start(start), .busy(busy_w), .done(done_w), .error(error_w),
        .cur_stage(cur_stage_w), .stage_start(stage_start_w), .stage_done(stage_done),
        .st_r_addr(st_r_addr), .st_r_en(st_r_en), .st_r_q(st_r_q_w),
        .st_w_addr(st_w_addr), .st_w_en(st_w_en), .st_w_we(st_w_we), .st_w_d(st_w_d),
        .bram_r_addr(bram_r_addr_w), .bram_r_en(bram_r_en_w), .bram_w_addr(bram_w_addr_w),
        .bram_w_en(bram_w_en_w), .bram_w_we(bram_w_we_w), .bram_w_d(bram_w_d_w), .bram_r_q(bram_r_q));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got hang, expected summary");
        $fatal(1);
    end

    // Stub stages: stage i raises done dly[i]+1 cycles after its start pulse; dly<0 hangs.
    task automatic stub_step(input bit use_w);
        logic [NS-1:0] ss;
        ss = use_w ? stage_start_w : stage_start;
        stage_done = '0;
        for (int i = 0; i < NS; i++) begin
            if (cnt[i] > 0) begin
                cnt[i] = cnt[i] - 1;
                if (cnt[i] == 0) stage_done[i] = 1'b1;
            end
        end
        for (int i = 0; i < NS; i++)
            if (ss[i] && dly[i] >= 0) cnt[i] = dly[i] + 1;
    endtask

    task automatic set_requests();
        st_r_addr = {13'h1234, 13'h0042, 13'h1234};
        st_w_addr = {13'h1234, 13'h0055, 13'h1234};
        st_r_en   = 3'b111;
        st_w_en   = 3'b111;
        st_w_we   = 3'b101;
        st_w_d    = {16'hbeef, 16'h5a5a, 16'hdead};
        bram_r_q  = 16'h00ab;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stage_done = '0;
        st_r_addr = '0; st_w_addr = '0; st_r_en = '0; st_w_en = '0; st_w_we = '0;
        st_w_d = '0; bram_r_q = '0;
        for (int i = 0; i < NS; i++) cnt[i] = 0;
        exp_stage.delete(); exp_evt.delete(); exp_bram.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stage_done = '0;
        set_requests();
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, error} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags: got %b, expected 000", {busy, done, error});
        end
        vectors++;
        if ({stage_start, cur_stage} !== '0) begin
            miscompares++; $display("FAIL reset_stage: got %b, expected 0", {stage_start, cur_stage});
        end
        vectors++;
        if ({bram_r_addr, bram_r_en, bram_w_addr, bram_w_en, bram_w_we, bram_w_d} !== '0) begin
            miscompares++; $display("FAIL reset_bram: got %h, expected 0",
                {bram_r_addr, bram_r_en, bram_w_addr, bram_w_en, bram_w_we, bram_w_d});
        end
        vectors++;
        if ({busy_w, done_w, error_w, stage_start_w, cur_stage_w, bram_r_en_w, bram_w_en_w} !== '0) begin
            miscompares++; $display("FAIL reset_wdut: got %b, expected 0",
                {busy_w, done_w, error_w, stage_start_w, cur_stage_w, bram_r_en_w, bram_w_en_w});
        end
        vectors++;
        if (st_r_q !== 16'h00ab) begin
            miscompares++; $display("FAIL reset_rq: got %h, expected 00ab", st_r_q);
        end
    endtask

    task automatic test_nominal();
        logic [NS-1:0] e;
        do_reset();
        dly = '{10, 20, 5};
        exp_stage.push_back(0); exp_stage.push_back(1); exp_stage.push_back(2);
        exp_evt.push_back(42);
        start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (stage_start != '0) begin
                vectors++;
                if (exp_stage.size() == 0) begin
                    miscompares++; $display("FAIL nominal_order: got extra stage_start %b at cycle %0d", stage_start, k);
                end else begin
                    e = NS'(1) << exp_stage.pop_front();
                    if (stage_start !== e) begin
                        miscompares++; $display("FAIL nominal_order: got %b, expected %b", stage_start, e);
                    end
                end
            end
            if (done) begin
                vectors++;
                if (exp_evt.size() == 0) begin
                    miscompares++; $display("FAIL nominal_done: got extra done at cycle %0d", k);
                end else begin
                    int c;
                    c = exp_evt.pop_front();
                    if (k != c) begin
                        miscompares++; $display("FAIL nominal_done: got cycle %0d, expected %0d", k, c);
                    end
                end
            end
            stub_step(1'b0);
        end
        vectors++;
        if (exp_stage.size() + exp_evt.size() != 0) begin
            miscompares++; $display("FAIL nominal_missing: got %0d events outstanding, expected 0",
                exp_stage.size() + exp_evt.size());
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL nominal_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_grant();
        int g, b0, e0, b1, e1, b2, e2;
        bram_t exp, act;
        do_reset();
        set_requests();
        dly = '{3, 8, 3};
        b0 = 1;      e0 = b0 + dly[0] + 1;
        b1 = e0 + 1; e1 = b1 + dly[1] + 1;
        b2 = e1 + 1; e2 = b2 + dly[2] + 1;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            g = (k >= b0 && k <= e0) ? 0 : (k >= b1 && k <= e1) ? 1 : (k >= b2 && k <= e2) ? 2 : -1;
            exp = '0;
            if (g >= 0) begin
                exp.ra   = st_r_addr[g*AW +: AW];
                exp.re   = st_r_en[g];
                exp.wa   = st_w_addr[g*AW +: AW];
                exp.we_n = st_w_en[g];
                exp.wwe  = st_w_we[g];
                exp.wd   = st_w_d[g*DW +: DW];
            end
            exp_bram.push_back(exp);
            act = {bram_r_addr, bram_r_en, bram_w_addr, bram_w_en, bram_w_we, bram_w_d};
            exp = exp_bram.pop_front();
            vectors++;
            if (act !== exp) begin
                miscompares++; $display("FAIL grant_bram: cycle %0d got %h, expected %h", k, act, exp);
            end
            vectors++;
            if (st_r_q !== 16'h00ab) begin
                miscompares++; $display("FAIL grant_rq: got %h, expected 00ab", st_r_q);
            end
            stub_step(1'b0);
        end
    endtask

    task automatic test_watchdog();
        bit seen = 1'b0;
        do_reset();
        set_requests();
        dly = '{2, -1, 2};
        exp_evt.push_back(22);
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (done_w !== 1'b0) begin
                miscompares++; $display("FAIL wdog_done: got done=%b at cycle %0d, expected 0", done_w, k);
            end
            if (error_w === 1'b1 && !seen) begin
                int c;
                seen = 1'b1;
                vectors++;
                c = (exp_evt.size() != 0) ? exp_evt.pop_front() : -1;
                if (k != c) begin
                    miscompares++; $display("FAIL wdog_cycle: got fault at %0d, expected %0d", k, c);
                end
            end
            if (k == 22) begin
                vectors++;
                if ({busy_w, bram_r_en_w, bram_w_en_w, bram_w_we_w, stage_start_w} !== '0) begin
                    miscompares++; $display("FAIL wdog_idle: got %b, expected 0",
                        {busy_w, bram_r_en_w, bram_w_en_w, bram_w_we_w, stage_start_w});
                end
            end
            stub_step(1'b1);
        end
        vectors++;
        if (error_w !== 1'b1 || exp_evt.size() != 0) begin
            miscompares++; $display("FAIL wdog_sticky: got error=%b outstanding=%0d, expected 1/0", error_w, exp_evt.size());
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({error_w, stage_start_w, cur_stage_w} !== {1'b0, 3'b001, 2'd0}) begin
            miscompares++; $display("FAIL wdog_restart: got %b, expected 0001_00", {error_w, stage_start_w, cur_stage_w});
        end
    endtask

    task automatic test_tie_spurious();
        logic [NS-1:0] e;
        bit err_seen = 1'b0;
        do_reset();
        dly = '{2, 15, 2};
        exp_stage.push_back(0); exp_stage.push_back(1); exp_stage.push_back(2);
        exp_evt.push_back(26);
        start = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            start = (k == 10);
            if (error_w) err_seen = 1'b1;
            if (stage_start_w != '0) begin
                vectors++;
                if (exp_stage.size() == 0) begin
                    miscompares++; $display("FAIL tie_order: got extra stage_start %b at cycle %0d", stage_start_w, k);
                end else begin
                    e = NS'(1) << exp_stage.pop_front();
                    if (stage_start_w !== e) begin
                        miscompares++; $display("FAIL tie_order: got %b, expected %b", stage_start_w, e);
                    end
                end
            end
            if (done_w) begin
                vectors++;
                if (exp_evt.size() == 0) begin
                    miscompares++; $display("FAIL tie_done: got extra done at cycle %0d", k);
                end else begin
                    int c;
                    c = exp_evt.pop_front();
                    if (k != c) begin
                        miscompares++; $display("FAIL tie_done: got cycle %0d, expected %0d", k, c);
                    end
                end
            end
            stub_step(1'b1);
            if (k == 2) stage_done[2] = 1'b1;
        end
        vectors++;
        if (err_seen) begin
            miscompares++; $display("FAIL tie_error: got error=1, expected 0");
        end
        vectors++;
        if (exp_stage.size() + exp_evt.size() != 0) begin
            miscompares++; $display("FAIL tie_missing: got %0d events outstanding, expected 0",
                exp_stage.size() + exp_evt.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [NS-1:0] e;
        do_reset();
        set_requests();
        dly = '{3, 10, 3};
        start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            stub_step(1'b0);
        end
        vectors++;
        if (cur_stage !== 2'd1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL midrst_pre: got stage=%0d busy=%b, expected 1/1", cur_stage, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, error, stage_start, cur_stage, bram_r_addr, bram_r_en, bram_w_addr,
             bram_w_en, bram_w_we, bram_w_d} !== '0) begin
            miscompares++; $display("FAIL midrst_out: got %h, expected 0", {busy, done, error, stage_start,
                cur_stage, bram_r_addr, bram_r_en, bram_w_addr, bram_w_en, bram_w_we, bram_w_d});
        end
        reset = 1'b0; stage_done = '0;
        for (int i = 0; i < NS; i++) cnt[i] = 0;
        exp_stage.push_back(0); exp_stage.push_back(1); exp_stage.push_back(2);
        exp_evt.push_back(10 + 23);
        start = 1'b1;
        for (int k = 11; k <= 50; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (stage_start != '0) begin
                vectors++;
                if (exp_stage.size() == 0) begin
                    miscompares++; $display("FAIL midrst_order: got extra stage_start %b at cycle %0d", stage_start, k);
                end else begin
                    e = NS'(1) << exp_stage.pop_front();
                    if (stage_start !== e) begin
                        miscompares++; $display("FAIL midrst_order: got %b, expected %b", stage_start, e);
                    end
                end
            end
            if (done) begin
                vectors++;
                if (exp_evt.size() == 0) begin
                    miscompares++; $display("FAIL midrst_done: got extra done at cycle %0d", k);
                end else begin
                    int c;
                    c = exp_evt.pop_front();
                    if (k != c) begin
                        miscompares++; $display("FAIL midrst_done: got cycle %0d, expected %0d", k, c);
                    end
                end
            end
            stub_step(1'b0);
        end
        vectors++;
        if (exp_stage.size() + exp_evt.size() != 0) begin
            miscompares++; $display("FAIL midrst_missing: got %0d events outstanding, expected 0",
                exp_stage.size() + exp_evt.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_grant();
        test_watchdog();
        test_tie_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
